// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and the initialisation fill rule for
// the multi-port register file.
package regfile_pkg;

  localparam int unsigned INIT_MODE_ZERO   = 0;
  localparam int unsigned INIT_MODE_INDEX  = 1;
  localparam int unsigned INIT_MODE_TRIPLE = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Returned wide; callers size-cast to XLEN, which zero-extends or truncates.
  function automatic logic [63:0] fill_value(input int unsigned mode, input logic [63:0] idx);
    case (mode)
      INIT_MODE_INDEX:  return idx;
      INIT_MODE_TRIPLE: return idx * 64'd3;
      default:          return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback, set wins on a
// same-cycle collision because the issuing instruction is the younger producer.
module regfile_scoreboard #(
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2,
  parameter int unsigned NW = 1
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             flush,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic [NW-1:0]    clr_en,
  input  logic [NW*AW-1:0] clr_addr,
  input  logic [NR*AW-1:0] rd_addr,
  input  logic [NR-1:0]    rd_hit,
  output logic [NR-1:0]    rd_busy
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DEPTH-1:0] busy_q, busy_d;

  // NOTE: every always_comb starts from a full default so no path leaves a
  // bit unassigned, which would infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (clr_en[j]) busy_d[clr_addr[j*AW +: AW]] = 1'b0;
      end
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr       = rd_addr[i*AW +: AW];
    assign rd_busy[i] = busy_q[addr] & (addr != '0) & ~rd_hit[i];
  end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port register file: hardware init sweep, write-to-read bypass,
// hardwired x0 and a busy scoreboard for outstanding producers.
module mp_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned NR        = 2,
  parameter int unsigned NW        = 1,
  parameter int unsigned INIT_MODE = 0,
  parameter int unsigned BYPASS    = 1
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic               iss_en,
  input  logic [AW-1:0]      iss_addr,
  input  logic               init_req,
  output logic               ready
);

  localparam int unsigned DEPTH = 2 ** AW;

  state_e          state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            run, accept, flush, iss_ok;
  logic [NW-1:0]   wr_ok;
  logic [NR-1:0]   rd_hit;
  logic [XLEN-1:0] fill_val;
  logic [XLEN-1:0] rf_q [DEPTH];

  assign run      = (state_q == RUN);
  assign ready    = run;
  assign flush    = run & init_req;
  assign accept   = run & ~init_req;
  assign iss_ok   = accept & iss_en & (iss_addr != '0);
  assign fill_val = XLEN'(fill_value(INIT_MODE, 64'(cnt_q)));

  for (genvar j = 0; j < NW; j++) begin : g_wr
    assign wr_ok[j] = accept & wr_en[j] & (wr_addr[j*AW +: AW] != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      if (cnt_q == (AW+1)'(DEPTH - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (init_req) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are defined only by
  // the sweep, which keeps it mappable onto plain RAM/flop arrays.
  // Later ports are assigned last, so the highest write port wins a collision.
  always_ff @(posedge cpu_clk) begin
    if (!run) begin
      rf_q[cnt_q[AW-1:0]] <= fill_val;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_ok[j]) rf_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            hit;
    logic [XLEN-1:0] byp;
    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NW; j++) begin
        if ((BYPASS != 0) && run && wr_en[j] && (wr_addr[j*AW +: AW] == addr) && (addr != '0)) begin
          hit = 1'b1;
          byp = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    assign rd_hit[i]                 = hit;
    assign rd_data[i*XLEN +: XLEN]   = (addr == '0) ? '0 : (hit ? byp : rf_q[addr]);
  end

  regfile_scoreboard #(
    .AW (AW),
    .NR (NR),
    .NW (NW)
  ) u_scoreboard (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .flush    (flush),
    .set_en   (iss_ok),
    .set_addr (iss_addr),
    .clr_en   (wr_ok),
    .clr_addr (wr_addr),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_busy  (rd_busy)
  );

endmodule
